sirc_user_responder: RTL and testbench
======================================

Name: sirc_user_responder

Overview:
Responder side of the SIRC user interface. Services the user circuit's handshakes on three ports: parameter register file read/write, input-memory read, and output-memory write. Also owns the run register.
A simple host port loads parameters and input bytes, starts a run, and reads back output bytes. Sits between the host/Ethernet infrastructure and user handlers such as the PUF challenge/response handler. It is also used as the synthesizable bench responder for those handlers.

Parameters:
INMEM_BYTE_WIDTH, 1, input-memory word width in bytes (power of 2)
OUTMEM_BYTE_WIDTH, 1, output-memory word width in bytes (power of 2)
INMEM_ADDRESS_WIDTH, 5, input-memory address bits; depth = 2**INMEM_ADDRESS_WIDTH words
OUTMEM_ADDRESS_WIDTH, 4, output-memory address bits
NUM_REGS, 4, number of 32-bit parameter registers (1..256)
READ_LATENCY, 2, cycles from accepted read to data-valid (>=1), same for register and input-memory reads

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
userRunValue  out  1  run register value
userRunClear  in  1  user request to clear run register
register32CmdReq  in  1  parameter command request
register32CmdAck  out  1  command accepted when Req&&Ack
register32WriteData  in  32  parameter write data
register32Address  in  8  parameter address
register32WriteEn  in  1  1=write, 0=read
register32ReadDataValid  out  1  read-return strobe
register32ReadData  out  32  read-return data
inputMemoryReadReq  in  1  input read request
inputMemoryReadAck  out  1  read accepted when Req&&Ack
inputMemoryReadAdd  in  INMEM_ADDRESS_WIDTH  read address
inputMemoryReadDataValid  out  1  read-return strobe
inputMemoryReadData  out  8*INMEM_BYTE_WIDTH  read-return data
outputMemoryWriteReq  in  1  output write request
outputMemoryWriteAck  out  1  write accepted when Req&&Ack
outputMemoryWriteAdd  in  OUTMEM_ADDRESS_WIDTH  write address
outputMemoryWriteData  in  8*OUTMEM_BYTE_WIDTH  write data
outputMemoryWriteByteMask  in  OUTMEM_BYTE_WIDTH  per-byte write enable
hostSel  in  2  0=param regs, 1=input mem, 2=output mem, 3=none
hostAddr  in  16  host word address (LSBs used per target)
hostWrEn  in  1  host write (targets 0,1; ignored for 2)
hostWrData  in  32  host write data (LSBs used for memories)
hostRdEn  in  1  host read (any target)
hostRdData  out  32  host read data, zero-extended
hostRdValid  out  1  host read strobe, 1 cycle after hostRdEn
hostStart  in  1  set run register
hostDone  out  1  1-cycle pulse when run register falls 1->0

Behaviour:
- Reset: all outputs 0, run register 0, parameter registers 0, read pipelines flushed so no valid emerges afterwards. Memory contents are not cleared.
- Acks are combinational: Ack = Req && !hostConflict. hostConflict is true when hostWrEn or hostRdEn targets the same resource (hostSel) in that cycle; the host always wins.
- One acceptance per cycle per port; back-to-back accepts are allowed.
- Reads: an acceptance at edge t captures the content at that edge. Valid/data are high for exactly the cycle following edge t+READ_LATENCY-1, i.e. READ_LATENCY cycles after the request cycle. Returns are in order. ReadData is 0 whenever Valid is 0.
- Register writes (WriteEn=1): update on the accept edge, produce no ReadDataValid. Address >= NUM_REGS: reads return 0, writes are dropped, and the command is still acked.
- Output writes: the masked bytes update on the accept edge.
- Host same-cycle write and user read of the same word: cannot occur, because the conflict rule prevents it.
- Run register:
  - hostStart sets it to 1.
  - userRunClear clears it to 0; if both occur in the same cycle, clear wins.
  - hostStart while already 1 has no effect.
  - hostDone is asserted in the cycle after the register goes 1->0.
- Host read: data registered, hostRdValid asserted 1 cycle later. hostWrEn and hostRdEn together: write performed, read returns the pre-write value.

Decomposition:
- Package sirc_pkg: hostSel codes (HOST_SEL_PARAM/INMEM/OUTMEM/NONE) and the 32-bit register data width constant.
- Sub-module sirc_read_pipe (params WIDTH, LATENCY): valid/data shift pipeline with flush on reset. Instantiated once for register reads and once for input-memory reads.

Test Plan:
- Host writes reg0=0x1234, reg1=0xBEEF; user holds CmdReq with addresses 0 then 1 on consecutive accepts -> ReadDataValid at cycles t+2 and t+3 with 0x1234, 0xBEEF.
- Host loads inmem[0..15]=0x10..0x1F; user reads 0..15 one per cycle -> 16 valids returning 0x10..0x1F in order, none dropped.
- User writes outmem[2]=0xA5 with mask 1, then mask 0 with 0xFF -> host read of addr 2 returns 0x000000A5 one cycle after hostRdEn.
- hostStart -> userRunValue=1; userRunClear plus hostStart in the same cycle -> run=0, hostDone pulses 1 cycle later; hostStart while run=1 -> no change.
- Host write to inmem in the same cycle as user inputMemoryReadReq -> inputMemoryReadAck=0 that cycle, ack=1 the next; read returns the newly written byte.
- Reset asserted one cycle after a register-read accept -> no ReadDataValid ever appears; reg5 read with NUM_REGS=4 -> acked, returns 0.

Source files
------------

// File: rtl/sirc_pkg.sv
// sirc_pkg: shared host-select codes and register width for the SIRC responder slice
package sirc_pkg;
  localparam logic [1:0] HOST_SEL_PARAM = 2'd0;
  localparam logic [1:0] HOST_SEL_INMEM = 2'd1;
  localparam logic [1:0] HOST_SEL_OUTMEM = 2'd2;
  localparam logic [1:0] HOST_SEL_NONE = 2'd3;
  localparam int REG_WIDTH = 32;
endpackage

// File: rtl/sirc_read_pipe.sv
// sirc_read_pipe: fixed-latency valid/data return pipeline, flushed by reset
module sirc_read_pipe #(
  parameter int WIDTH = 32,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inValid,
  input  logic [WIDTH-1:0] inData,
  output logic             outValid,
  output logic [WIDTH-1:0] outData
);
  logic [LATENCY-1:0] validQ;
  logic [WIDTH-1:0] dataQ [LATENCY];
  // data is forced to zero on idle slots so the output is 0 whenever valid is 0
  always_ff @(posedge clk) begin
    if (reset) begin
      validQ <= '0;
      for (int i = 0; i < LATENCY; i++) dataQ[i] <= '0;
    end else begin
      validQ[0] <= inValid;
      dataQ[0] <= inValid ? inData : '0;
      for (int i = 1; i < LATENCY; i++) begin
        validQ[i] <= validQ[i-1];
        dataQ[i] <= dataQ[i-1];
      end
    end
  end
  assign outValid = validQ[LATENCY-1];
  assign outData = dataQ[LATENCY-1];
endmodule

// File: rtl/sirc_user_responder.sv
// sirc_user_responder: services user register/memory handshakes and owns the run register
module sirc_user_responder
  import sirc_pkg::*;
#(
  parameter int INMEM_BYTE_WIDTH = 1,
  parameter int OUTMEM_BYTE_WIDTH = 1,
  parameter int INMEM_ADDRESS_WIDTH = 5,
  parameter int OUTMEM_ADDRESS_WIDTH = 4,
  parameter int NUM_REGS = 4,
  parameter int READ_LATENCY = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  output logic                              userRunValue,
  input  logic                              userRunClear,
  input  logic                              register32CmdReq,
  output logic                              register32CmdAck,
  input  logic [REG_WIDTH-1:0]              register32WriteData,
  input  logic [7:0]                        register32Address,
  input  logic                              register32WriteEn,
  output logic                              register32ReadDataValid,
  output logic [REG_WIDTH-1:0]              register32ReadData,
  input  logic                              inputMemoryReadReq,
  output logic                              inputMemoryReadAck,
  input  logic [INMEM_ADDRESS_WIDTH-1:0]    inputMemoryReadAdd,
  output logic                              inputMemoryReadDataValid,
  output logic [8*INMEM_BYTE_WIDTH-1:0]     inputMemoryReadData,
  input  logic                              outputMemoryWriteReq,
  output logic                              outputMemoryWriteAck,
  input  logic [OUTMEM_ADDRESS_WIDTH-1:0]   outputMemoryWriteAdd,
  input  logic [8*OUTMEM_BYTE_WIDTH-1:0]    outputMemoryWriteData,
  input  logic [OUTMEM_BYTE_WIDTH-1:0]      outputMemoryWriteByteMask,
  input  logic [1:0]                        hostSel,
  input  logic [15:0]                       hostAddr,
  input  logic                              hostWrEn,
  input  logic [31:0]                       hostWrData,
  input  logic                              hostRdEn,
  output logic [31:0]                       hostRdData,
  output logic                              hostRdValid,
  input  logic                              hostStart,
  output logic                              hostDone
);
  localparam int IW = 8 * INMEM_BYTE_WIDTH;
  localparam int OW = 8 * OUTMEM_BYTE_WIDTH;
  localparam int RW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
  localparam logic [16:0] NREG = 17'(NUM_REGS);
  logic [REG_WIDTH-1:0] regs [1<<RW];
  logic [IW-1:0] inMem [1<<INMEM_ADDRESS_WIDTH];
  logic [OW-1:0] outMem [1<<OUTMEM_ADDRESS_WIDTH];
  logic hostAct, userRegOk, hostRegOk, runNext;
  logic [REG_WIDTH-1:0] userRegData, hostRdNext;
  assign hostAct = hostWrEn || hostRdEn;
  assign register32CmdAck = register32CmdReq && !(hostAct && hostSel == HOST_SEL_PARAM);
  assign inputMemoryReadAck = inputMemoryReadReq && !(hostAct && hostSel == HOST_SEL_INMEM);
  assign outputMemoryWriteAck = outputMemoryWriteReq && !(hostAct && hostSel == HOST_SEL_OUTMEM);
  assign userRegOk = {9'b0, register32Address} < NREG;
  assign hostRegOk = {1'b0, hostAddr} < NREG;
  assign userRegData = userRegOk ? regs[register32Address[RW-1:0]] : '0;
  assign runNext = userRunClear ? 1'b0 : (hostStart ? 1'b1 : userRunValue);
  always_comb begin
    hostRdNext = '0;
    hostRdNext = !hostRdEn ? '0 :
                 hostSel == HOST_SEL_PARAM ? (hostRegOk ? regs[hostAddr[RW-1:0]] : '0) :
                 hostSel == HOST_SEL_INMEM ? 32'(inMem[hostAddr[INMEM_ADDRESS_WIDTH-1:0]]) :
                 hostSel == HOST_SEL_OUTMEM ? 32'(outMem[hostAddr[OUTMEM_ADDRESS_WIDTH-1:0]]) : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < (1 << RW); i++) regs[i] <= '0;
      userRunValue <= 1'b0;
      hostDone <= 1'b0;
      hostRdData <= '0;
      hostRdValid <= 1'b0;
    end else begin
      if (hostWrEn && hostSel == HOST_SEL_PARAM && hostRegOk)
        regs[hostAddr[RW-1:0]] <= hostWrData;
      else if (register32CmdAck && register32WriteEn && userRegOk)
        regs[register32Address[RW-1:0]] <= register32WriteData;
      userRunValue <= runNext;
      hostDone <= userRunValue && !runNext;
      hostRdData <= hostRdNext;
      hostRdValid <= hostRdEn;
    end
  end
  // memory contents survive reset
  always_ff @(posedge clk) begin
    if (hostWrEn && hostSel == HOST_SEL_INMEM)
      inMem[hostAddr[INMEM_ADDRESS_WIDTH-1:0]] <= hostWrData[IW-1:0];
    if (outputMemoryWriteAck)
      for (int b = 0; b < OUTMEM_BYTE_WIDTH; b++)
        if (outputMemoryWriteByteMask[b])
          outMem[outputMemoryWriteAdd][8*b +: 8] <= outputMemoryWriteData[8*b +: 8];
  end
  sirc_read_pipe #(.WIDTH(REG_WIDTH), .LATENCY(READ_LATENCY)) regPipe (
    .clk(clk), .reset(reset),
    .inValid(register32CmdAck && !register32WriteEn), .inData(userRegData),
    .outValid(register32ReadDataValid), .outData(register32ReadData)
  );
  sirc_read_pipe #(.WIDTH(IW), .LATENCY(READ_LATENCY)) inPipe (
    .clk(clk), .reset(reset),
    .inValid(inputMemoryReadAck), .inData(inMem[inputMemoryReadAdd]),
    .outValid(inputMemoryReadDataValid), .outData(inputMemoryReadData)
  );
endmodule

// File: tb/tb_sirc_user_responder.sv
// tb_sirc_user_responder: directed checks of handshakes, read latency, host port and run register
module tb_sirc_user_responder;
  logic clk = 1'b0, reset = 1'b1;
  logic userRunValue, userRunClear = 1'b0;
  logic register32CmdReq = 1'b0, register32CmdAck, register32WriteEn = 1'b0, register32ReadDataValid;
  logic [31:0] register32WriteData = '0, register32ReadData;
  logic [7:0] register32Address = '0;
  logic inputMemoryReadReq = 1'b0, inputMemoryReadAck, inputMemoryReadDataValid;
  logic [4:0] inputMemoryReadAdd = '0;
  logic [7:0] inputMemoryReadData;
  logic outputMemoryWriteReq = 1'b0, outputMemoryWriteAck;
  logic [3:0] outputMemoryWriteAdd = '0;
  logic [7:0] outputMemoryWriteData = '0;
  logic [0:0] outputMemoryWriteByteMask = '0;
  logic [1:0] hostSel = 2'd3;
  logic [15:0] hostAddr = '0;
  logic hostWrEn = 1'b0, hostRdEn = 1'b0, hostRdValid, hostStart = 1'b0, hostDone;
  logic [31:0] hostWrData = '0, hostRdData;
  int assertCount = 0, failCount = 0;

  sirc_user_responder dut (
    .clk(clk), .reset(reset), .userRunValue(userRunValue), .userRunClear(userRunClear),
    .register32CmdReq(register32CmdReq), .register32CmdAck(register32CmdAck),
    .register32WriteData(register32WriteData), .register32Address(register32Address),
    .register32WriteEn(register32WriteEn), .register32ReadDataValid(register32ReadDataValid),
    .register32ReadData(register32ReadData), .inputMemoryReadReq(inputMemoryReadReq),
    .inputMemoryReadAck(inputMemoryReadAck), .inputMemoryReadAdd(inputMemoryReadAdd),
    .inputMemoryReadDataValid(inputMemoryReadDataValid), .inputMemoryReadData(inputMemoryReadData),
    .outputMemoryWriteReq(outputMemoryWriteReq), .outputMemoryWriteAck(outputMemoryWriteAck),
    .outputMemoryWriteAdd(outputMemoryWriteAdd), .outputMemoryWriteData(outputMemoryWriteData),
    .outputMemoryWriteByteMask(outputMemoryWriteByteMask), .hostSel(hostSel), .hostAddr(hostAddr),
    .hostWrEn(hostWrEn), .hostWrData(hostWrData), .hostRdEn(hostRdEn), .hostRdData(hostRdData),
    .hostRdValid(hostRdValid), .hostStart(hostStart), .hostDone(hostDone)
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick();
    tick();
    checkValue("rst run", 32'(userRunValue), 0);
    checkValue("rst done", 32'(hostDone), 0);
    checkValue("rst rdvalid", 32'(hostRdValid), 0);
    checkValue("rst regvalid", 32'(register32ReadDataValid), 0);
    checkValue("rst memvalid", 32'(inputMemoryReadDataValid), 0);
    reset = 1'b0;
    // register read latency with back-to-back accepts
    hostSel = 2'd0; hostWrEn = 1'b1;
    hostAddr = 16'd0; hostWrData = 32'h1234; tick();
    hostAddr = 16'd1; hostWrData = 32'hBEEF; tick();
    hostWrEn = 1'b0; hostSel = 2'd3;
    register32CmdReq = 1'b1; register32Address = 8'd0; #1;
    checkValue("reg ack", 32'(register32CmdAck), 1);
    tick();
    register32Address = 8'd1; tick();
    register32CmdReq = 1'b0;
    checkValue("reg0 valid", 32'(register32ReadDataValid), 1);
    checkValue("reg0 data", register32ReadData, 32'h1234);
    tick();
    checkValue("reg1 valid", 32'(register32ReadDataValid), 1);
    checkValue("reg1 data", register32ReadData, 32'hBEEF);
    tick();
    checkValue("reg idle valid", 32'(register32ReadDataValid), 0);
    checkValue("reg idle data", register32ReadData, 0);
    // input memory streaming reads
    hostSel = 2'd1; hostWrEn = 1'b1;
    for (int i = 0; i < 16; i++) begin
      hostAddr = 16'(i); hostWrData = 32'h10 + 32'(i); tick();
    end
    hostWrEn = 1'b0; hostSel = 2'd3;
    for (int i = 0; i < 18; i++) begin
      inputMemoryReadReq = i < 16;
      inputMemoryReadAdd = 5'(i);
      tick();
      if (i == 0) checkValue("mem first idle", 32'(inputMemoryReadDataValid), 0);
      if (i >= 1 && i <= 16) begin
        checkValue("mem stream valid", 32'(inputMemoryReadDataValid), 1);
        checkValue("mem stream data", 32'(inputMemoryReadData), 32'h10 + 32'(i - 1));
      end
    end
    checkValue("mem tail valid", 32'(inputMemoryReadDataValid), 0);
    // masked output writes then host readback
    outputMemoryWriteReq = 1'b1; outputMemoryWriteAdd = 4'd2;
    outputMemoryWriteData = 8'hA5; outputMemoryWriteByteMask = 1'b1; tick();
    outputMemoryWriteData = 8'hFF; outputMemoryWriteByteMask = 1'b0; tick();
    outputMemoryWriteReq = 1'b0;
    hostSel = 2'd2; hostAddr = 16'd2; hostRdEn = 1'b1; tick();
    hostRdEn = 1'b0; hostSel = 2'd3;
    checkValue("out rd valid", 32'(hostRdValid), 1);
    checkValue("out rd data", hostRdData, 32'h000000A5);
    tick();
    checkValue("out rd idle", 32'(hostRdValid), 0);
    // run register
    hostStart = 1'b1; tick();
    checkValue("run set", 32'(userRunValue), 1);
    tick();
    checkValue("run hold", 32'(userRunValue), 1);
    checkValue("run no done", 32'(hostDone), 0);
    userRunClear = 1'b1; tick();
    userRunClear = 1'b0; hostStart = 1'b0;
    checkValue("run cleared", 32'(userRunValue), 0);
    checkValue("done pulse", 32'(hostDone), 1);
    tick();
    checkValue("done end", 32'(hostDone), 0);
    // host/user conflict on input memory
    hostSel = 2'd1; hostWrEn = 1'b1; hostAddr = 16'd3; hostWrData = 32'h77;
    inputMemoryReadReq = 1'b1; inputMemoryReadAdd = 5'd3; #1;
    checkValue("conflict ack", 32'(inputMemoryReadAck), 0);
    tick();
    hostWrEn = 1'b0; hostSel = 2'd3; #1;
    checkValue("post conflict ack", 32'(inputMemoryReadAck), 1);
    tick();
    inputMemoryReadReq = 1'b0;
    tick();
    checkValue("conflict rd valid", 32'(inputMemoryReadDataValid), 1);
    checkValue("conflict rd data", 32'(inputMemoryReadData), 32'h77);
    // reset flushes an in-flight register read
    register32CmdReq = 1'b1; register32Address = 8'd0; tick();
    register32CmdReq = 1'b0; reset = 1'b1; tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkValue("flush valid", 32'(register32ReadDataValid), 0);
      tick();
    end
    hostSel = 2'd0; hostAddr = 16'd1; hostRdEn = 1'b1; hostWrEn = 1'b1; hostWrData = 32'h55; tick();
    hostWrEn = 1'b0;
    checkValue("rmw old value", hostRdData, 0);
    tick();
    hostRdEn = 1'b0; hostSel = 2'd3;
    checkValue("rmw new value", hostRdData, 32'h55);
    // out-of-range register
    register32CmdReq = 1'b1; register32Address = 8'd5; #1;
    checkValue("oob ack", 32'(register32CmdAck), 1);
    tick();
    register32CmdReq = 1'b0;
    tick();
    checkValue("oob valid", 32'(register32ReadDataValid), 1);
    checkValue("oob data", register32ReadData, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
